// File: rtl/gpio_status_sequencer.sv
// gpio_status_sequencer
//   Drives the board GPIO status LEDs from the four compute cores of the
//   accelerator. Each core has a small job-state machine:
//     idle  -> LED off
//     run   -> LED slow blink
//     done  -> LED solid on
//     error -> LED fast blink
//   led_done lights once every core has finished.
//
//   A host debug port can take over all five LEDs for OVR_HOLD blink ticks.
//   It uses a valid/ready handshake.
//
// Optional feature
//   GPIO_HEARTBEAT_EN : when defined, led_done shows a slow-blink heartbeat
//                       while any core is running and no override is active.
//
// Parameters
//   BLINK_DIV : clk cycles per blink tick (>= 2)
//   OVR_HOLD  : blink ticks an accepted override pattern is held (>= 1)
//
// Ports
//   clk        in  : system clock, rising edge
//   rst        in  : asynchronous reset, active low
//   core_start in  : per-core pulse, job launched
//   core_done  in  : per-core pulse, job completed
//   core_err   in  : per-core pulse, job faulted
//   clear      in  : pulse, return all cores to idle and restart blink timing
//   ovr_valid  in  : host override request
//   ovr_leds   in  : override pattern {led_done, led4, led3, led2, led1}
//   ovr_ready  out : override can be accepted this cycle
//   led1..led4 out : core 0..3 status LEDs
//   led_done   out : all-cores-done LED
module gpio_status_sequencer #(
   parameter int BLINK_DIV = 5_000_000,
   parameter int OVR_HOLD  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] core_start,
   input  logic [3:0] core_done,
   input  logic [3:0] core_err,
   input  logic       clear,
   input  logic       ovr_valid,
   input  logic [4:0] ovr_leds,
   output logic       ovr_ready,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic       led4,
   output logic       led_done
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int HW = $clog2(OVR_HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } core_state_t;

   core_state_t       state      [4];
   core_state_t       state_next [4];
   logic [CW-1:0]     presc;
   logic [1:0]        phase;
   logic              tick;
   logic [HW-1:0]     hold_cnt;
   logic [4:0]        ovr_pat;
   logic [4:0]        status_leds;
   logic [4:0]        leds_q;
   logic              ovr_ready_q;
   logic              accept;
   logic              release_ovr;
   logic              all_done;
   logic              any_run;

   assign tick        = (presc == CW'(BLINK_DIV - 1));
   assign accept      = ovr_valid & ovr_ready_q;
   // The hold ends on the tick that completes OVR_HOLD ticks after the accept.
   assign release_ovr = ~ovr_ready_q & tick & (hold_cnt == HW'(OVR_HOLD - 1));

   // Next job state for each core.
   // Event priority is clear > err > done > start.
   // The error state is sticky until a clear.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_next[i] = state[i];
         if (clear) begin
            state_next[i] = S_IDLE;
         end else if (core_err[i]) begin
            state_next[i] = S_ERR;
         end else begin
            case (state[i])
               S_IDLE:  if (core_start[i]) state_next[i] = S_RUN;
               S_RUN:   if (core_done[i])  state_next[i] = S_DONE;
               S_DONE:  if (core_start[i]) state_next[i] = S_RUN;
               default: state_next[i] = S_ERR;
            endcase
         end
      end
   end

   // Render the current job states into LED levels.
   // phase[1] gives the slow blink and phase[0] gives the fast blink.
   always_comb begin
      status_leds = '0;
      all_done    = 1'b1;
      any_run     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         case (state[i])
            S_IDLE:  status_leds[i] = 1'b0;
            S_RUN:   status_leds[i] = phase[1];
            S_DONE:  status_leds[i] = 1'b1;
            default: status_leds[i] = phase[0];
         endcase
         if (state[i] != S_DONE) all_done = 1'b0;
         if (state[i] == S_RUN)  any_run  = 1'b1;
      end
`ifdef GPIO_HEARTBEAT_EN
      status_leds[4] = all_done | (any_run & phase[1]);
`else
      status_leds[4] = all_done | (any_run & 1'b0);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc       <= '0;
         phase       <= 2'd0;
         hold_cnt    <= '0;
         ovr_pat     <= '0;
         leds_q      <= '0;
         ovr_ready_q <= 1'b1;
         for (int i = 0; i < 4; i++) state[i] <= S_IDLE;
      end else begin
         presc <= (clear || tick) ? '0 : presc + CW'(1);
         if (clear)     phase <= 2'd0;
         else if (tick) phase <= phase + 2'd1;
         for (int i = 0; i < 4; i++) state[i] <= state_next[i];

         // The override owns the LED registers while it is active.
         // The job state machines keep running underneath.
         // A clear does not cancel the override.
         if (accept) begin
            ovr_ready_q <= 1'b0;
            hold_cnt    <= '0;
            ovr_pat     <= ovr_leds;
            leds_q      <= ovr_leds;
         end else if (release_ovr) begin
            ovr_ready_q <= 1'b1;
            leds_q      <= status_leds;
         end else if (!ovr_ready_q) begin
            if (tick) hold_cnt <= hold_cnt + HW'(1);
            leds_q <= ovr_pat;
         end else begin
            leds_q <= status_leds;
         end
      end
   end

   assign ovr_ready = ovr_ready_q;
   assign led1      = leds_q[0];
   assign led2      = leds_q[1];
   assign led3      = leds_q[2];
   assign led4      = leds_q[3];
   assign led_done  = leds_q[4];

endmodule

// File: tb/tb_gpio_status_sequencer.sv
// tb_gpio_status_sequencer
//   Self-checking bench for gpio_status_sequencer.
//   Directed scenarios and random core events are applied to the DUT.
//   Every cycle the DUT outputs are compared against a behavioural model.
//   The model keeps each core's job state as an integer.
//   It derives blink timing arithmetically from the cycles elapsed since reset or clear.
module tb_gpio_status_sequencer;

   localparam int BLINK_DIV = 4;
   localparam int OVR_HOLD  = 2;

   localparam int M_IDLE = 10;
   localparam int M_RUN  = 11;
   localparam int M_DONE = 12;
   localparam int M_ERR  = 13;

   logic       clk;
   logic       rst;
   logic [3:0] core_start;
   logic [3:0] core_done;
   logic [3:0] core_err;
   logic       clear;
   logic       ovr_valid;
   logic [4:0] ovr_leds;
   logic       ovr_ready;
   logic       led1, led2, led3, led4, led_done;

   int         checks;
   int         errors;

   // Reference model state
   int         mSt [4];
   int         mT;
   bit         mAct;
   int         mLeft;
   logic [4:0] mPat;
   logic [4:0] mLed;
   logic       mReady;

   gpio_status_sequencer #(
      .BLINK_DIV (BLINK_DIV),
      .OVR_HOLD  (OVR_HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_start (core_start),
      .core_done  (core_done),
      .core_err   (core_err),
      .clear      (clear),
      .ovr_valid  (ovr_valid),
      .ovr_leds   (ovr_leds),
      .ovr_ready  (ovr_ready),
      .led1       (led1),
      .led2       (led2),
      .led3       (led3),
      .led4       (led4),
      .led_done   (led_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mSt[i] = M_IDLE;
      mT     = 0;
      mAct   = 1'b0;
      mLeft  = 0;
      mPat   = '0;
      mLed   = '0;
      mReady = 1'b1;
   endtask

   // LED levels implied by the current model job states.
   // Blink timing is derived from the cycles elapsed since reset or clear.
   function automatic logic [4:0] renderStatus();
      logic [4:0] r;
      int         ph;
      bit         allDone;
      bit         anyRun;
      ph      = (mT / BLINK_DIV) % 4;
      allDone = 1'b1;
      anyRun  = 1'b0;
      r       = '0;
      for (int i = 0; i < 4; i++) begin
         if (mSt[i] == M_RUN)  r[i] = (ph >= 2);
         if (mSt[i] == M_DONE) r[i] = 1'b1;
         if (mSt[i] == M_ERR)  r[i] = (ph % 2) == 1;
         if (mSt[i] != M_DONE) allDone = 1'b0;
         if (mSt[i] == M_RUN)  anyRun  = 1'b1;
      end
`ifdef GPIO_HEARTBEAT_EN
      r[4] = allDone || (anyRun && ph >= 2);
`else
      r[4] = allDone;
`endif
      return r;
   endfunction

   task automatic modelStep(input logic [3:0] s, input logic [3:0] d, input logic [3:0] e,
                            input logic c, input logic ov, input logic [4:0] ol);
      bit         tick;
      logic [4:0] status;
      tick   = (mT % BLINK_DIV) == BLINK_DIV - 1;
      status = renderStatus();
      if (ov && !mAct) begin
         mAct  = 1'b1;
         mLeft = OVR_HOLD;
         mPat  = ol;
         mLed  = ol;
      end else if (mAct) begin
         if (tick) mLeft--;
         if (mLeft == 0) begin
            mAct = 1'b0;
            mLed = status;
         end else begin
            mLed = mPat;
         end
      end else begin
         mLed = status;
      end
      mReady = !mAct;
      for (int i = 0; i < 4; i++) begin
         if (c)         mSt[i] = M_IDLE;
         else if (e[i]) mSt[i] = M_ERR;
         else if (mSt[i] == M_IDLE && s[i]) mSt[i] = M_RUN;
         else if (mSt[i] == M_RUN  && d[i]) mSt[i] = M_DONE;
         else if (mSt[i] == M_DONE && s[i]) mSt[i] = M_RUN;
      end
      mT = c ? 0 : mT + 1;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare.
   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] d, input logic [3:0] e,
                                input logic c, input logic ov, input logic [4:0] ol);
      core_start = s;
      core_done  = d;
      core_err   = e;
      clear      = c;
      ovr_valid  = ov;
      ovr_leds   = ol;
      @(posedge clk);
      modelStep(s, d, e, c, ov, ol);
      #1;
      checkOutput("leds", {27'd0, led_done, led4, led3, led2, led1}, {27'd0, mLed});
      checkOutput("ovr_ready", {31'd0, ovr_ready}, {31'd0, mReady});
      core_start = '0;
      core_done  = '0;
      core_err   = '0;
      clear      = 1'b0;
      ovr_valid  = 1'b0;
      ovr_leds   = '0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
   endtask

   function automatic logic [3:0] randPulse(input int oneIn);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, oneIn - 1) == 0);
      return p;
   endfunction

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      core_start = '0;
      core_done  = '0;
      core_err   = '0;
      clear      = 1'b0;
      ovr_valid  = 1'b0;
      ovr_leds   = '0;
      modelReset();

      // Reset state, then a quiet period with no inputs
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset_leds", {27'd0, led_done, led4, led3, led2, led1}, 32'd0);
      checkOutput("reset_ready", {31'd0, ovr_ready}, 32'd1);
      rst = 1'b1;
      idle(100);

      // A single core running gives a slow blink on led1
      applyStimulus(4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(40);

      // All cores start, then finish at staggered times
      applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(3);
      applyStimulus(4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(2);
      applyStimulus(4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(5);
      applyStimulus(4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(1);
      applyStimulus(4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(1);
      checkOutput("all_done", {31'd0, led_done}, 32'd1);
      idle(4);

      // An error that coincides with a done wins, then clear, then restart
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
      applyStimulus(4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(3);
      applyStimulus(4'h0, 4'h4, 4'h4, 1'b0, 1'b0, 5'h00);
      idle(20);
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
      idle(1);
      checkOutput("clear_led3", {31'd0, led3}, 32'd0);
      applyStimulus(4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
      idle(3);
      applyStimulus(4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(10);

      // Override while cores are busy; later requests during the hold are not taken
      applyStimulus(4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 5'b10101);
      for (int k = 0; k < 6; k++) applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 5'b01010);
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
      idle(20);

      // Random core events, clears and override requests
      for (int k = 0; k < 3000; k++) begin
         applyStimulus(randPulse(5), randPulse(6), randPulse(40),
                       ($urandom_range(0, 59) == 0),
                       ($urandom_range(0, 11) == 0),
                       5'($urandom_range(0, 31)));
      end

      // Reset asserted between clock edges clears the outputs immediately
      applyStimulus(4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 5'h00);
      applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
      idle(9);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_leds", {27'd0, led_done, led4, led3, led2, led1}, 32'd0);
      checkOutput("async_ready", {31'd0, ovr_ready}, 32'd1);
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
